// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: registered binary adder tree summing N_IN unsigned operands
// at full precision, with one global stall enable and optional saturation.
module adder_tree_pipe #(
  parameter int N_IN = 7,
  parameter int W    = 8,
  parameter bit SAT  = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              sum,
  output logic [W+$clog2(N_IN)-1:0] sum_full,
  output logic                      ovf
);
  localparam int L  = $clog2(N_IN);
  localparam int WF = W + L;
  localparam logic [WF-1:0] MAX_W = WF'({W{1'b1}});

  typedef logic [N_IN-1:0][WF-1:0] level_t;

  if (N_IN < 2 || N_IN > 16) begin : g_bad_n
    $error("adder_tree_pipe: N_IN must be within 2..16");
  end
  if (W < 2 || W > 32) begin : g_bad_w
    $error("adder_tree_pipe: W must be within 2..32");
  end

  function automatic logic ovf_of(input logic [WF-1:0] v);
    return v > MAX_W;
  endfunction

  function automatic logic [W-1:0] sat_fn(input logic [WF-1:0] v);
    if (SAT && ovf_of(v)) return '1;
    return v[W-1:0];
  endfunction

  logic         adv;
  logic [L-1:0] vld_q, vld_d;
  level_t       lvl_q [L];
  level_t       lvl_d [L];
  logic [W-1:0] sum_q;
  logic         ovf_q;

  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_q[L-1];
  assign sum       = sum_q;
  assign sum_full  = lvl_q[L-1][0];
  assign ovf       = ovf_q;

  always_comb begin
    vld_d[0] = in_valid;
    for (int i = 1; i < L; i++) vld_d[i] = vld_q[i-1];
  end

  // Each level folds entry k of the previous level into slot k/2, so pairs
  // add and an odd trailing entry passes through unchanged.
  always_comb begin : p_tree
    level_t src;
    int     cnt;
    src = '0;
    for (int k = 0; k < N_IN; k++) src[k] = WF'(in_data[k*W +: W]);
    cnt = N_IN;
    for (int i = 0; i < L; i++) begin
      lvl_d[i] = '0;
      for (int k = 0; k < N_IN; k++) begin
        if (k < cnt) lvl_d[i][k/2] = lvl_d[i][k/2] + src[k];
      end
      cnt = (cnt + 1) / 2;
      src = lvl_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < L; i++) lvl_q[i] <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      vld_q <= vld_d;
      for (int i = 0; i < L; i++) lvl_q[i] <= lvl_d[i];
      sum_q <= sat_fn(lvl_d[L-1][0]);
      ovf_q <= ovf_of(lvl_d[L-1][0]);
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe: default geometry, saturating variant and
// a geometry sweep, each driven with hand-computed vectors.
module tb_adder_tree_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [55:0] in_data;
  logic [7:0]  sum;
  logic [10:0] sum_full;
  logic        s_in_ready, s_out_valid, s_ovf;
  logic [7:0]  s_sum;
  logic [10:0] s_sum_full;

  logic        g_valid, g_ready;
  logic        g2_in_ready, g2_out_valid, g2_ovf;
  logic [7:0]  g2_data;
  logic [3:0]  g2_sum;
  logic [4:0]  g2_full;
  logic        g8_in_ready, g8_out_valid, g8_ovf;
  logic [63:0] g8_data;
  logic [7:0]  g8_sum;
  logic [10:0] g8_full;
  logic         g9_in_ready, g9_out_valid, g9_ovf;
  logic [143:0] g9_data;
  logic [15:0]  g9_sum;
  logic [19:0]  g9_full;

  adder_tree_pipe #(.N_IN(7), .W(8), .SAT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .sum_full(sum_full), .ovf(ovf));

  adder_tree_pipe #(.N_IN(7), .W(8), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .sum(s_sum), .sum_full(s_sum_full), .ovf(s_ovf));

  adder_tree_pipe #(.N_IN(2), .W(4), .SAT(1'b0)) u_g2 (
    .clk(clk), .rst_n(rst_n), .in_valid(g_valid), .in_ready(g2_in_ready),
    .in_data(g2_data), .out_valid(g2_out_valid), .out_ready(g_ready),
    .sum(g2_sum), .sum_full(g2_full), .ovf(g2_ovf));

  adder_tree_pipe #(.N_IN(8), .W(8), .SAT(1'b0)) u_g8 (
    .clk(clk), .rst_n(rst_n), .in_valid(g_valid), .in_ready(g8_in_ready),
    .in_data(g8_data), .out_valid(g8_out_valid), .out_ready(g_ready),
    .sum(g8_sum), .sum_full(g8_full), .ovf(g8_ovf));

  adder_tree_pipe #(.N_IN(9), .W(16), .SAT(1'b0)) u_g9 (
    .clk(clk), .rst_n(rst_n), .in_valid(g_valid), .in_ready(g9_in_ready),
    .in_data(g9_data), .out_valid(g9_out_valid), .out_ready(g_ready),
    .sum(g9_sum), .sum_full(g9_full), .ovf(g9_ovf));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] ops7(input int v);
    logic [55:0] r;
    for (int k = 0; k < 7; k++) r[k*8 +: 8] = v[7:0];
    return r;
  endfunction

  // Drive one vector into the N_IN=7 pair and check that it emerges on the third edge.
  task automatic push7(input string tag, input logic [55:0] d);
    in_data  = d;
    in_valid = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, "_valid"}, out_valid, (e == 3));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_q [$];
    logic [63:0] held, exp_v;
    logic        hold_chk;
    logic [55:0] mix;
    int j, rx, c;

    in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    g_valid = 1'b0; g_ready = 1'b1;
    g2_data = '1; g8_data = '1; g9_data = '1;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 8'd0);
    chk("rst_full", sum_full, 11'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_ready", {in_ready, s_in_ready, g2_in_ready, g8_in_ready, g9_in_ready}, 5'b11111);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    push7("unit", ops7(1));
    chk("unit_sum", sum, 8'd7);
    chk("unit_full", sum_full, 11'd7);
    chk("unit_ovf", ovf, 1'b0);
    chk("unit_sat_sum", s_sum, 8'd7);

    push7("wrap", ops7(255));
    chk("wrap_full", sum_full, 11'd1785);
    chk("wrap_sum", sum, 8'hF9);
    chk("wrap_ovf", ovf, 1'b1);
    chk("sat_sum", s_sum, 8'hFF);
    chk("sat_full", s_sum_full, 11'h6F9);
    chk("sat_ovf", s_ovf, 1'b1);

    mix = '0;
    mix[7:0] = 8'd100; mix[15:8] = 8'd100; mix[23:16] = 8'd55;
    push7("mix", mix);
    chk("mix_sum", sum, 8'd255);
    chk("mix_ovf", ovf, 1'b0);
    chk("mix_sat_sum", s_sum, 8'd255);
    chk("mix_sat_ovf", s_ovf, 1'b0);
    @(posedge clk); #1;
    chk("mix_drain", out_valid, 1'b0);

    j = 0; rx = 0; c = 0;
    while (c < 40 && rx < 10) begin
      out_ready = !(c >= 4 && c <= 7);
      in_valid  = (j < 10);
      in_data   = ops7(j);
      #1;
      chk("bp_in_ready", in_ready, out_ready || !out_valid);
      hold_chk = 1'b0;
      if (out_valid && out_ready) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd999;
        chk("bp_order", sum, exp_v);
        rx++;
      end
      if (out_valid && !out_ready) begin
        held = sum; hold_chk = 1'b1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(64'(7 * j));
        j++;
      end
      @(posedge clk); #1;
      if (hold_chk) begin
        chk("bp_stall_valid", out_valid, 1'b1);
        chk("bp_stall_hold", sum, held);
      end
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", rx, 10);
    chk("bp_accepted", j, 10);
    @(posedge clk); #1;
    chk("bp_drain", out_valid, 1'b0);

    in_valid = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      in_data = ops7(v);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_valid_before", out_valid, 1'b1);
    chk("mid_sum_before", sum, 8'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_sum", sum, 8'd0);
    chk("mid_rst_full", sum_full, 11'd0);
    chk("mid_rst_ovf", ovf, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    #1 rst_n = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      chk("mid_no_stale", out_valid, 1'b0);
    end
    push7("post", ops7(5));
    chk("post_sum", sum, 8'd35);
    chk("post_full", sum_full, 11'd35);

    g_valid = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      g_valid = 1'b0;
      chk("g2_valid", g2_out_valid, (e == 1));
      chk("g8_valid", g8_out_valid, (e == 3));
      chk("g9_valid", g9_out_valid, (e == 4));
      if (e == 1) begin
        chk("g2_full", g2_full, 5'd30);
        chk("g2_sum", g2_sum, 4'd14);
        chk("g2_ovf", g2_ovf, 1'b1);
      end
      if (e == 3) begin
        chk("g8_full", g8_full, 11'd2040);
        chk("g8_sum", g8_sum, 8'd248);
        chk("g8_ovf", g8_ovf, 1'b1);
      end
      if (e == 4) begin
        chk("g9_full", g9_full, 20'd589815);
        chk("g9_sum", g9_sum, 16'd65527);
        chk("g9_ovf", g9_ovf, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
